// File: rtl/par_check_stream.sv
// rtl/par_check_stream.sv - streaming frame parity checker with one-deep verdict slot and saturating error counter
module par_check_stream #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_par,
  input  logic              mode_odd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_err,
  output logic              out_parity,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_sat,
  input  logic              clear_cnt
);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t           r_state;
  logic             r_acc;
  logic             r_mode;
  logic             r_out_valid;
  logic             r_out_err;
  logic             r_out_parity;
  logic [CNT_W-1:0] r_err_count;

  logic w_accept;
  logic w_finish;
  logic w_beat_par;
  logic w_mode;
  logic w_acc_in;
  logic w_p;
  logic w_err;
  logic w_drain;
  logic w_cnt_max;

  // A finishing frame can refill the slot in the same cycle it is drained.
  assign in_ready   = ~r_out_valid | out_ready;
  assign w_accept   = in_valid & in_ready;
  assign w_finish   = w_accept & in_last;
  assign w_drain    = r_out_valid & out_ready;
  assign w_beat_par = ^in_data;
  assign w_mode     = (r_state == S_IDLE) ? mode_odd : r_mode;
  assign w_acc_in   = (r_state == S_IDLE) ? 1'b0 : r_acc;
  assign w_p        = w_acc_in ^ w_beat_par ^ w_mode;
  assign w_err      = w_p ^ in_par;
  assign w_cnt_max  = &r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= 1'b0;
      r_mode  <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (!in_last) begin
            r_acc   <= w_beat_par;
            r_mode  <= mode_odd;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          if (in_last) begin
            r_acc   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc <= r_acc ^ w_beat_par;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_parity <= 1'b0;
    end else if (w_finish) begin
      r_out_valid  <= 1'b1;
      r_out_err    <= w_err;
      r_out_parity <= w_p;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  // Clear wins over a coincident errored verdict, which is then not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (clear_cnt) begin
      r_err_count <= '0;
    end else if (w_finish && w_err && !w_cnt_max) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_err    = r_out_err;
  assign out_parity = r_out_parity;
  assign err_count  = r_err_count;
  assign err_sat    = w_cnt_max;

endmodule

// File: doc/par_check_stream.md
Name: par_check_stream

Overview:
- Streaming, parametrised parity checker for multi-beat frames of DATA_W-bit words.
- Accumulates parity across a frame under a valid/ready handshake.
- On the last beat, compares the accumulated parity against a supplied parity bit in even or odd mode.
- Returns a per-frame verdict through a one-deep result register and keeps a saturating error counter. Sits between a word source and a status/monitor consumer.

Parameters:
DATA_W, 4, width of each data beat in bits (>=1)
CNT_W, 8, width of the frame-error counter (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  beat present on in_data
in_ready  output  1  block can accept a beat this cycle
in_data  input  DATA_W  data beat
in_last  input  1  beat is the final beat of its frame
in_par  input  1  expected parity bit; sampled only on the last beat
mode_odd  input  1  0 = even parity, 1 = odd parity; sampled on the first beat of a frame
out_valid  output  1  frame verdict held in result register
out_ready  input  1  consumer takes the verdict
out_err  output  1  1 = parity mismatch for the reported frame
out_parity  output  1  computed parity for the reported frame
err_count  output  CNT_W  number of errored frames, saturating
err_sat  output  1  err_count at its maximum value, 2^CNT_W-1
clear_cnt  input  1  synchronous clear of err_count

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_err=0, out_parity=0, err_count=0, err_sat=0.
  - Accumulator=0, mode register=0, FSM=IDLE.
  - in_ready=1 once reset is released.
- Beat acceptance: accept = in_valid & in_ready.
  - in_ready = ~out_valid | out_ready, combinational from registered out_valid and the out_ready input. No dependency on in_valid or in_last.
- FSM states: IDLE (no frame open) and ACC (frame open).
  - IDLE, accept & ~in_last: acc <= ^in_data; mode_r <= mode_odd; go to ACC.
  - IDLE, accept & in_last: single-beat frame; finish the frame using mode_odd directly; stay IDLE.
  - ACC, accept & ~in_last: acc <= acc ^ (^in_data); mode_odd ignored.
  - ACC, accept & in_last: finish the frame; go to IDLE; acc <= 0.
  - No accept: state and acc hold.
- Frame finish, with m = frame mode:
  - p = acc_in ^ (^in_data) ^ m, where acc_in = 0 in IDLE.
  - Next cycle: out_parity <= p, out_err <= (p != in_par), out_valid <= 1.
  - Latency is one cycle from last-beat acceptance to out_valid.
- Result register:
  - Holds out_valid, out_err and out_parity stable until out_valid & out_ready.
  - On that handshake, out_valid drops to 0 unless a new frame finishes in the same cycle. In that case the new verdict loads with no bubble.
- Mid-frame beats stall while the result slot is full and not being drained. No beat is ever dropped.
- Error counter:
  - Increments by 1 in the same cycle the errored verdict is loaded into the result register.
  - Saturates at 2^CNT_W-1 with no wrap; err_sat = (err_count == all ones).
  - clear_cnt=1 forces err_count=0. It has priority over a coincident increment, and that event is not counted.
- Reset mid-frame discards the partial frame and any pending verdict; the first post-reset beat starts a new frame.
- A beat with in_valid=1 and in_ready=0 must be held stable by the source; the block samples nothing from it.
- Width rule: ^in_data is the reduction XOR over DATA_W bits; parity arithmetic is 1-bit XOR only.

Test Plan:
- Even mode, DATA_W=4: beats 4'b1011, then 4'b0001 with in_last, in_par=0 -> one cycle later out_valid=1, out_parity=0, out_err=0, err_count=0.
- Same frame with in_par=1 -> out_err=1, err_count=1. Then assert clear_cnt for one cycle -> err_count=0.
- Odd mode: single-beat frame 4'b0110 with in_last, mode_odd=1, in_par=1 -> out_parity=1, out_err=0. Also toggle mode_odd mid-frame on a 2-beat frame -> verdict uses the first-beat mode.
- Backpressure:
  - Hold out_ready=0 after a verdict -> in_ready=0, and a mid-frame beat stalls with its data unchanged.
  - Raise out_ready with a last beat pending -> verdict replaced in the same cycle with no gap; second verdict correct.
- Saturation, CNT_W=2: five consecutive errored frames -> err_count sequence 1, 2, 3, 3, 3, with err_sat=1 from the third frame. clear_cnt coincident with an errored verdict -> err_count=0.
- Reset mid-frame: pull rst_n low after the first of three beats -> outputs go to reset values immediately. After release, a new 1-beat frame 4'b0001 with in_par=1, even mode -> out_err=0.
